// File: rtl/traffic_interval_timer_if.sv
// Control/status bundle between the phase FSM (master) and the interval timer (slave).
interface traffic_interval_timer_if;
  logic       Reprogram;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic       Start_Timer;
  logic [1:0] Interval_Select;
  logic       Busy;
  logic       Expired;
  logic [3:0] Remaining;
  logic       One_Hz_Tick;

  modport master (
    output Reprogram, Time_Parameter_Selector, Time_Value, Start_Timer, Interval_Select,
    input  Busy, Expired, Remaining, One_Hz_Tick
  );

  modport slave (
    input  Reprogram, Time_Parameter_Selector, Time_Value, Start_Timer, Interval_Select,
    output Busy, Expired, Remaining, One_Hz_Tick
  );
endinterface

// File: rtl/traffic_interval_timer.sv
// Interval timer and time-parameter store for the traffic light controller.
// Holds base/extended/yellow durations, applies front-panel writes, and runs
// one seconds-countdown at a time, pulsing Expired for one cycle at the end.
module traffic_interval_timer #(
  parameter int         TICKS_PER_SEC = 100000000,
  parameter logic [3:0] DEF_BASE      = 4'd6,
  parameter logic [3:0] DEF_EXT       = 4'd3,
  parameter logic [3:0] DEF_YEL       = 4'd2
) (
  input logic                     clk,
  input logic                     Reset,
  traffic_interval_timer_if.slave tif
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [3:0]    remaining_r, remaining_s;
  logic          expired_r, expired_s;
  logic          one_hz_r, one_hz_s;
  logic [3:0]    base_r, base_s;
  logic [3:0]    ext_r, ext_s;
  logic [3:0]    yel_r, yel_s;
  logic          tick_s;

  // A written value of zero means "fall back to this register's default".
  function automatic logic [3:0] value_or_default(input logic [3:0] value, input logic [3:0] def);
    return (value == 4'd0) ? def : value;
  endfunction

  // Selector 11 is not a real interval; it is treated as the base interval.
  function automatic logic [3:0] select_interval(input logic [1:0] sel, input logic [3:0] b,
                                                 input logic [3:0] e, input logic [3:0] y);
    logic [3:0] v;
    case (sel)
      2'b01:   v = e;
      2'b10:   v = y;
      default: v = b;
    endcase
    return v;
  endfunction

  assign tick_s = (presc_r == PRESC_MAX);

  // Next-state logic: Reprogram beats Start_Timer, which beats the tick/expiry path.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    presc_s     = tick_s ? '0 : presc_r + PW'(1);
    expired_s   = 1'b0;
    one_hz_s    = tick_s;
    base_s      = base_r;
    ext_s       = ext_r;
    yel_s       = yel_r;
    if (tif.Reprogram) begin
      case (tif.Time_Parameter_Selector)
        2'b00: base_s = value_or_default(tif.Time_Value, DEF_BASE);
        2'b01: ext_s  = value_or_default(tif.Time_Value, DEF_EXT);
        2'b10: yel_s  = value_or_default(tif.Time_Value, DEF_YEL);
        2'b11: begin
          base_s = DEF_BASE;
          ext_s  = DEF_EXT;
          yel_s  = DEF_YEL;
        end
        default: begin
          base_s = base_r;
        end
      endcase
      state_s     = IDLE;
      remaining_s = 4'd0;
      presc_s     = '0;
      one_hz_s    = 1'b0;
    end else if (tif.Start_Timer) begin
      state_s     = COUNT;
      remaining_s = select_interval(tif.Interval_Select, base_r, ext_r, yel_r);
      presc_s     = '0;
      one_hz_s    = 1'b0;
    end else if ((state_r == COUNT) && tick_s) begin
      if (remaining_r == 4'd1) begin
        remaining_s = 4'd0;
        expired_s   = 1'b1;
        state_s     = IDLE;
      end else begin
        remaining_s = remaining_r - 4'd1;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, prescaler, parameter store and output registers; reset returns to defaults.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      presc_r     <= '0;
      remaining_r <= 4'd0;
      expired_r   <= 1'b0;
      one_hz_r    <= 1'b0;
      base_r      <= DEF_BASE;
      ext_r       <= DEF_EXT;
      yel_r       <= DEF_YEL;
    end else begin
      state_r     <= state_s;
      presc_r     <= presc_s;
      remaining_r <= remaining_s;
      expired_r   <= expired_s;
      one_hz_r    <= one_hz_s;
      base_r      <= base_s;
      ext_r       <= ext_s;
      yel_r       <= yel_s;
    end
  end

  assign tif.Busy        = (state_r == COUNT);
  assign tif.Expired     = expired_r;
  assign tif.Remaining   = remaining_r;
  assign tif.One_Hz_Tick = one_hz_r;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboard bench for traffic_interval_timer with a 4-cycle second.
module tb_traffic_interval_timer;

  localparam int T = 4;

  logic clk;
  logic Reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   exp_q[$];
  int   m_base, m_ext, m_yel;

  traffic_interval_timer_if tif();

  traffic_interval_timer #(
    .TICKS_PER_SEC(T),
    .DEF_BASE(4'd6),
    .DEF_EXT(4'd3),
    .DEF_YEL(4'd2)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .tif  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_interval(input logic [1:0] sel);
    case (sel)
      2'b01:   return m_ext;
      2'b10:   return m_yel;
      default: return m_base;
    endcase
  endfunction

  // Compare each Expired pulse against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (tif.Expired === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_expired", int'(tif.Expired), 0);
      end else begin
        check_eq("expire_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic start_timer(input logic [1:0] sel);
    int n;
    n = model_interval(sel);
    tif.Start_Timer     = 1'b1;
    tif.Interval_Select = sel;
    exp_q.delete();
    exp_q.push_back(cyc + 1 + n * T);
    @(negedge clk);
    tif.Start_Timer = 1'b0;
    check_eq("start_busy", int'(tif.Busy), 1);
    check_eq("start_remaining", int'(tif.Remaining), n);
  endtask

  task automatic reprogram(input logic [1:0] sel, input logic [3:0] val, input logic with_start);
    tif.Reprogram               = 1'b1;
    tif.Time_Parameter_Selector = sel;
    tif.Time_Value              = val;
    tif.Start_Timer             = with_start;
    case (sel)
      2'b00:   m_base = (val == 4'd0) ? 6 : int'(val);
      2'b01:   m_ext  = (val == 4'd0) ? 3 : int'(val);
      2'b10:   m_yel  = (val == 4'd0) ? 2 : int'(val);
      default: begin m_base = 6; m_ext = 3; m_yel = 2; end
    endcase
    exp_q.delete();
    @(negedge clk);
    tif.Reprogram   = 1'b0;
    tif.Start_Timer = 1'b0;
    check_eq("reprog_busy", int'(tif.Busy), 0);
    check_eq("reprog_remaining", int'(tif.Remaining), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("expire_timeout", exp_q.size(), 0);
    @(negedge clk);
    check_eq("idle_busy", int'(tif.Busy), 0);
  endtask

  initial begin
    int ticks;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    m_base  = 6;
    m_ext   = 3;
    m_yel   = 2;
    Reset                       = 1'b0;
    tif.Reprogram               = 1'b0;
    tif.Time_Parameter_Selector = 2'b00;
    tif.Time_Value              = 4'd0;
    tif.Start_Timer             = 1'b0;
    tif.Interval_Select         = 2'b00;

    #1;
    check_eq("rst_busy", int'(tif.Busy), 0);
    check_eq("rst_expired", int'(tif.Expired), 0);
    check_eq("rst_remaining", int'(tif.Remaining), 0);
    check_eq("rst_tick", int'(tif.One_Hz_Tick), 0);
    @(negedge clk);
    Reset = 1'b1;

    // Free-running prescaler in IDLE: one tick every T cycles.
    ticks = 0;
    repeat (4 * T) begin
      @(negedge clk);
      if (tif.One_Hz_Tick === 1'b1) ticks++;
    end
    check_eq("idle_tick_count", ticks, 4);

    // Base interval from reset with full trajectory.
    start_timer(2'b00);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      check_eq("base_remaining", int'(tif.Remaining), (i < 24) ? 6 - i / T : 0);
      check_eq("base_busy", int'(tif.Busy), (i < 24) ? 1 : 0);
    end
    wait_idle();

    // Program yellow, then base still at default.
    reprogram(2'b10, 4'd5, 1'b0);
    start_timer(2'b10);
    wait_idle();
    start_timer(2'b00);
    wait_idle();

    // Zero value and restore-all.
    reprogram(2'b01, 4'd0, 1'b0);
    start_timer(2'b01);
    wait_idle();
    reprogram(2'b00, 4'd9, 1'b0);
    reprogram(2'b11, 4'd12, 1'b0);
    start_timer(2'b00);
    wait_idle();

    // Restart mid-count: base, then yellow 10 cycles later.
    start_timer(2'b00);
    repeat (9) @(negedge clk);
    start_timer(2'b10);
    wait_idle();
    repeat (20) @(negedge clk);

    // Reprogram aborts a running count at cycle 7.
    start_timer(2'b00);
    repeat (6) @(negedge clk);
    reprogram(2'b10, 4'd2, 1'b0);
    repeat (40) @(negedge clk);

    // Simultaneous Reprogram and Start: write wins, no start.
    reprogram(2'b00, 4'd7, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("simul_busy", int'(tif.Busy), 0);
    start_timer(2'b00);
    wait_idle();

    // Asynchronous reset mid-count; parameters revert.
    reprogram(2'b01, 4'd10, 1'b0);
    reprogram(2'b10, 4'd11, 1'b0);
    start_timer(2'b01);
    repeat (5) @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("arst_busy", int'(tif.Busy), 0);
    check_eq("arst_remaining", int'(tif.Remaining), 0);
    check_eq("arst_expired", int'(tif.Expired), 0);
    exp_q.delete();
    m_base = 6;
    m_ext  = 3;
    m_yel  = 2;
    @(negedge clk);
    Reset = 1'b1;
    start_timer(2'b00);
    wait_idle();
    start_timer(2'b01);
    wait_idle();
    start_timer(2'b10);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
